fetch_queue: RTL

Parametrised instruction prefetch buffer between the PC/instruction ROM and the IF/ID pipeline register. It replaces the single-entry fetch path with a DEPTH-entry FIFO of {instruction, PC}, kept full by an internal fetch PC. It drains under control of the IF/ID load enable. A taken-branch flush discards all queued entries and redirects fetch in one cycle.

---
 rtl/fetch_queue.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between the instruction ROM and IF/ID.
// An internal fetch PC keeps the queue topped up with {instruction, PC} pairs.
// The queue drains on deq_ready. A flush empties it and redirects fetch.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   rom_addr          byte address presented to the ROM (fetch_pc low bits)
//   rom_data          instruction returned combinationally by the ROM
//   deq_ready         consumer accepts the head entry this cycle
//   deq_valid         head entry valid
//   deq_instr/deq_pc  head instruction and its PC; held while empty
//   deq_next_pc       deq_pc + 4
//   flush             taken branch: discard queue and load flush_target
//   flush_target      new fetch address
//   count/full/empty  occupancy status
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                         clk,
    input  logic                         reset,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    input  logic                         deq_ready,
    output logic                         deq_valid,
    output logic [DATA_W-1:0]            deq_instr,
    output logic [31:0]                  deq_pc,
    output logic [31:0]                  deq_next_pc,
    input  logic                         flush,
    input  logic [31:0]                  flush_target,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_instr [DEPTH];
    logic [31:0]       mem_pc    [DEPTH];

    logic [31:0]       fetch_pc, fetch_pc_nxt;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              full_nxt, empty_nxt, valid_nxt;
    logic [DATA_W-1:0] instr_nxt;
    logic [31:0]       pc_nxt, next_pc_nxt;
    logic              pop, push, bypass;

    assign rom_addr = fetch_pc[ADDR_W-1:0];

    // Next-state computation; flush overrides any push/pop in the same cycle.
    always_comb begin
        pop          = deq_valid & deq_ready;
        push         = ~full | pop;
        fetch_pc_nxt = fetch_pc;
        rd_ptr_nxt   = rd_ptr;
        wr_ptr_nxt   = wr_ptr;
        count_nxt    = count;
        full_nxt     = full;
        empty_nxt    = empty;
        valid_nxt    = deq_valid;
        instr_nxt    = deq_instr;
        pc_nxt       = deq_pc;
        next_pc_nxt  = deq_next_pc;
        bypass       = 1'b0;

        if (flush) begin
            fetch_pc_nxt = flush_target;
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
            count_nxt    = '0;
            full_nxt     = 1'b0;
            empty_nxt    = 1'b1;
            valid_nxt    = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_nxt   = wr_ptr + PTR_W'(1);
                fetch_pc_nxt = fetch_pc + 32'd4;
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PTR_W'(1);
            end
            count_nxt = count + CNT_W'(push) - CNT_W'(pop);
            full_nxt  = (count_nxt == CNT_W'(DEPTH));
            empty_nxt = (count_nxt == '0);
            valid_nxt = ~empty_nxt;
            // Head register tracks entry[rd_ptr]; the slot being written this
            // edge is forwarded straight from the ROM.
            if (!empty_nxt) begin
                bypass      = push && (rd_ptr_nxt == wr_ptr);
                instr_nxt   = bypass ? rom_data : mem_instr[rd_ptr_nxt];
                pc_nxt      = bypass ? fetch_pc : mem_pc[rd_ptr_nxt];
                next_pc_nxt = pc_nxt + 32'd4;
            end
        end
    end

    // Control and head registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            deq_valid   <= 1'b0;
            deq_instr   <= '0;
            deq_pc      <= '0;
            deq_next_pc <= 32'd4;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            count       <= count_nxt;
            full        <= full_nxt;
            empty       <= empty_nxt;
            deq_valid   <= valid_nxt;
            deq_instr   <= instr_nxt;
            deq_pc      <= pc_nxt;
            deq_next_pc <= next_pc_nxt;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_instr[wr_ptr] <= rom_data;
            mem_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule
